// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the dm_1k front-end arbiter: access sizes, FSM states,
// port ownership and the misalignment rule.
package dm_arbiter_pkg;

  localparam logic DM_BYTE = 1'b0;
  localparam logic DM_WORD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } dm_owner_e;

  // Word accesses must be 4-byte aligned; byte accesses are legal anywhere.
  function automatic logic dm_misaligned(input logic sel, input logic [1:0] lsb);
    return (sel == DM_WORD) && (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// Two-way grant picker: round-robin against last_grant, or fixed priority to m0.
module dm_rr_pick
  import dm_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic      req0,
  input  logic      req1,
  input  dm_owner_e last_grant,
  output logic      gnt_valid,
  output dm_owner_e gnt
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt       = OWN_M0;
    if (PRIO_MODE != 0) begin
      gnt = req0 ? OWN_M0 : OWN_M1;
    end else if (req0 && req1) begin
      gnt = (last_grant == OWN_M0) ? OWN_M1 : OWN_M0;
    end else begin
      gnt = req0 ? OWN_M0 : OWN_M1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates CPU (m0) and loader (m1) onto the single dm_1k port, filters
// misaligned word accesses and returns a registered one-cycle response.
//
// state     | meaning
// ST_IDLE   | waiting for a request; picks a winner and latches its fields
// ST_ACCESS | memory port driven for one cycle; write commits at its end
// ST_RESP   | ack/err/rdata presented to the owner for one cycle
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  input  logic              m0_sel,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  input  logic              m1_sel,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_WriteEn,
  output logic              dm_sel,
  input  logic [DATA_W-1:0] dm_dout
);

  dm_state_e         state;
  dm_owner_e         owner;
  dm_owner_e         last_grant;
  dm_owner_e         gnt;
  logic              gnt_valid;
  logic              lat_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic              gnt_we;
  logic              gnt_sel;
  logic              gnt_err;

  dm_rr_pick #(.PRIO_MODE(PRIO_MODE)) u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  assign gnt_addr  = (gnt == OWN_M1) ? m1_addr  : m0_addr;
  assign gnt_wdata = (gnt == OWN_M1) ? m1_wdata : m0_wdata;
  assign gnt_we    = (gnt == OWN_M1) ? m1_we    : m0_we;
  assign gnt_sel   = (gnt == OWN_M1) ? m1_sel   : m0_sel;
  assign gnt_err   = dm_misaligned(gnt_sel, gnt_addr[1:0]);

  // Decoded from state so an async reset removes the strobe immediately.
  assign dm_WriteEn = lat_we & (state == ST_ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_M0;
      last_grant <= OWN_M1;
      lat_we     <= 1'b0;
      dm_addr    <= '0;
      dm_din     <= '0;
      dm_sel     <= 1'b0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
    end else begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner      <= gnt;
            last_grant <= gnt;
            lat_we     <= gnt_we;
            if (gnt_err) begin
              state <= ST_RESP;
              if (gnt == OWN_M0) begin
                m0_ack <= 1'b1;
                m0_err <= 1'b1;
              end else begin
                m1_ack <= 1'b1;
                m1_err <= 1'b1;
              end
            end else begin
              // The memory-side fields double as the latched request, so they
              // only move on accesses that actually reach dm_1k.
              dm_addr <= gnt_addr;
              dm_din  <= gnt_wdata;
              dm_sel  <= gnt_sel;
              state   <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
          if (owner == OWN_M0) begin
            m0_ack   <= 1'b1;
            m0_rdata <= dm_dout;
          end else begin
            m1_ack   <= 1'b1;
            m1_rdata <= dm_dout;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
